// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Converts parallel words into a serial bit stream for a downstream single-bit
// pattern detector. A word is accepted on a valid/ready handshake, emitted one
// bit per cycle starting the cycle after acceptance, and the next word may be
// accepted on the last bit of the current one so consecutive words run with
// no gap. Between words dout is held at 0.
//
// Parameters
//   WIDTH      parallel word width (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk         in   rising-edge clock for all state
//   rstn        in   synchronous active-low reset
//   din         in   parallel word to serialize
//   din_valid   in   din holds a word for transfer
//   din_ready   out  block accepts din this cycle (combinational)
//   dout        out  serial bit stream
//   dout_valid  out  dout carries a payload bit
//   word_cnt    out  words fully shifted out, wraps modulo 2^16
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic [15:0]      word_cnt
);

    localparam int             IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [WIDTH-1:0]   w_shreg_adv;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [15:0]        r_word_cnt;
    logic [15:0]        w_word_cnt_nxt;
    logic               w_last;
    logic               w_xfer;

    // Last bit of the current word is on dout: this is the only SHIFT cycle
    // in which a new word can be taken, which makes back-to-back gapless.
    assign w_last    = (r_state == SHIFT) && (r_idx == LAST_IDX);
    assign din_ready = rstn && ((r_state == IDLE) || w_last);
    assign w_xfer    = din_valid && din_ready;

    // Output end is the MSB or LSB; the register moves toward it, zero-filled.
    assign w_shreg_adv = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shreg[WIDTH-1:1]};

    assign dout       = (r_state == SHIFT) ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0])
                                           : 1'b0;
    assign dout_valid = (r_state == SHIFT);
    assign word_cnt   = r_word_cnt;

    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_idx_nxt      = r_idx;
        w_word_cnt_nxt = r_word_cnt;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_shreg_nxt = din;
                    w_idx_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!w_last) begin
                    w_shreg_nxt = w_shreg_adv;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                end else begin
                    w_word_cnt_nxt = r_word_cnt + 16'd1;
                    if (w_xfer) begin
                        w_shreg_nxt = din;
                        w_idx_nxt   = '0;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_idx      <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_idx      <= w_idx_nxt;
            r_word_cnt <= w_word_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Drives an MSB-first and an LSB-first bit_serializer (WIDTH=8) with the same
// directed and random stimulus and compares both against a queue-based
// reference: each accepted word becomes a queue of pending bits, the head of
// the queue is the expected dout, and the block is ready when at most one bit
// remains pending.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

    logic        clk;
    logic        rstn;
    logic [7:0]  din;
    logic        din_valid;

    logic        m_ready, m_dout, m_valid;
    logic [15:0] m_cnt;
    logic        l_ready, l_dout, l_valid;
    logic [15:0] l_cnt;

    int          checks;
    int          errors;

    bit          qm[$];
    bit          ql[$];
    logic [15:0] cnt_m;
    logic [15:0] cnt_l;
    logic [15:0] cap_m;
    logic [15:0] cap_l;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (m_ready),
        .dout       (m_dout),
        .dout_valid (m_valid),
        .word_cnt   (m_cnt)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (l_ready),
        .dout       (l_dout),
        .dout_valid (l_valid),
        .word_cnt   (l_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs after the falling edge, compare outputs,
    // then advance the reference model at the rising edge.
    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        bit rdy_m;
        bit rdy_l;
        rstn      = r;
        din_valid = v;
        din       = d;
        #1;
        rdy_m = r && (qm.size() <= 1);
        rdy_l = r && (ql.size() <= 1);
        chk("m_dout",  {15'd0, m_dout},  {15'd0, (qm.size() > 0) ? qm[0] : 1'b0});
        chk("m_valid", {15'd0, m_valid}, {15'd0, qm.size() > 0});
        chk("m_ready", {15'd0, m_ready}, {15'd0, rdy_m});
        chk("m_cnt",   m_cnt, cnt_m);
        chk("l_dout",  {15'd0, l_dout},  {15'd0, (ql.size() > 0) ? ql[0] : 1'b0});
        chk("l_valid", {15'd0, l_valid}, {15'd0, ql.size() > 0});
        chk("l_ready", {15'd0, l_ready}, {15'd0, rdy_l});
        chk("l_cnt",   l_cnt, cnt_l);
        if (m_valid === 1'b1) cap_m = {cap_m[14:0], m_dout};
        if (l_valid === 1'b1) cap_l = {cap_l[14:0], l_dout};
        @(posedge clk);
        if (!r) begin
            qm.delete();
            ql.delete();
            cnt_m = 16'd0;
            cnt_l = 16'd0;
        end else begin
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                if (qm.size() == 0) cnt_m = cnt_m + 16'd1;
            end
            if (ql.size() > 0) begin
                void'(ql.pop_front());
                if (ql.size() == 0) cnt_l = cnt_l + 16'd1;
            end
            if (v && rdy_m) for (int i = 0; i < 8; i++) qm.push_back(d[7-i]);
            if (v && rdy_l) for (int i = 0; i < 8; i++) ql.push_back(d[i]);
        end
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cnt_m     = 16'd0;
        cnt_l     = 16'd0;
        cap_m     = 16'd0;
        cap_l     = 16'd0;
        rstn      = 1'b0;
        din_valid = 1'b0;
        din       = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, with din_valid asserted during reset
        cyc(1'b0, 1'b1, 8'hFF);
        cyc(1'b0, 1'b0, 8'h00);

        // Single word 0x93
        cap_m = 16'd0;
        cap_l = 16'd0;
        cyc(1'b1, 1'b1, 8'h93);
        repeat (9) cyc(1'b1, 1'b0, 8'h00);
        chk("req028_bits_msb", cap_m, 16'h0093);
        chk("req032_bits_lsb", cap_l, 16'h00C9);
        chk("req028_cnt", m_cnt, 16'd1);

        // Back-to-back 0x90 then 0x09
        cap_m = 16'd0;
        cyc(1'b1, 1'b1, 8'h90);
        repeat (8) cyc(1'b1, 1'b1, 8'h09);
        repeat (9) cyc(1'b1, 1'b0, 8'h00);
        chk("req029_bits", cap_m, 16'h9009);
        chk("req029_cnt", m_cnt, 16'd3);

        // Offers while not ready are ignored
        cap_m = 16'd0;
        cyc(1'b1, 1'b1, 8'h55);
        cyc(1'b1, 1'b0, 8'h00);
        repeat (6) cyc(1'b1, 1'b1, 8'hFF);
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
        chk("req030_bits", cap_m, 16'h0055);
        chk("req030_cnt", m_cnt, 16'd4);

        // Reset mid-word abandons the word
        cyc(1'b1, 1'b1, 8'hA5);
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("req031_cnt", m_cnt, 16'd0);
        repeat (9) cyc(1'b1, 1'b0, 8'h00);
        chk("req031_cnt_after", m_cnt, 16'd0);

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), 8'($urandom));
        end
        repeat (10) cyc(1'b1, 1'b0, 8'h00);

        // Counter wrap: preload as though 65535 words had been sent
        force dut_m.r_word_cnt = 16'hFFFF;
        #1;
        release dut_m.r_word_cnt;
        cnt_m = 16'hFFFF;
        cyc(1'b1, 1'b0, 8'h00);
        chk("req033_preload", m_cnt, 16'hFFFF);
        cyc(1'b1, 1'b1, 8'h3C);
        repeat (7) cyc(1'b1, 1'b0, 8'h00);
        chk("req033_before_last", m_cnt, 16'hFFFF);
        cyc(1'b1, 1'b0, 8'h00);
        chk("req033_wrap", m_cnt, 16'h0000);
        repeat (3) cyc(1'b1, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
